// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide unit: operand width,
// funct3 operation codes and the sequencing FSM encoding.
package muldiv_pkg;
  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;
endpackage

// File: rtl/muldiv_iter_core.sv
// 32-step unsigned datapath: shift-add multiply or restoring divide, sharing
// one 64-bit accumulator. Operands arrive as magnitudes; signs live upstream.
module muldiv_iter_core
  import muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   init_lo,
  input  logic [XLEN-1:0]   opnd,
  output logic              last,
  output logic [2*XLEN-1:0] acc
);
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic [XLEN:0]     trial, diff, sum;
  logic              ge;

  always_comb begin
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    // Divide view: acc = {partial remainder, dividend bits shifting into quotient}
    trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff  = trial - {1'b0, opnd_q};
    ge    = (trial >= {1'b0, opnd_q});
    // Multiply view: acc = {running high product, remaining multiplier bits}
    sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    if (load) begin
      acc_d    = {{XLEN{1'b0}}, init_lo};
      opnd_d   = opnd;
      cnt_d    = '0;
      is_div_d = is_div;
    end else if (step) begin
      cnt_d = cnt_q + 5'd1;
      if (is_div_q)
        acc_d = {(ge ? diff[XLEN-1:0] : trial[XLEN-1:0]), acc_q[XLEN-2:0], ge};
      else
        acc_d = {sum, acc_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
    end
  end

  assign last = (cnt_q == 5'd31);
  assign acc  = acc_q;
endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: start/busy/done sequencing, operand sign prep,
// divide-by-zero/overflow shortcuts and final sign correction around the core.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Result
);
  md_state_e         state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d, rneg_q, rneg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_signed, b_signed, a_neg, b_neg, is_div, div0, ovf;
  logic [XLEN-1:0]   a_mag, b_mag, special_res, fix_res;
  logic [XLEN-1:0]   quot_fix, rem_fix;
  logic [2*XLEN-1:0] acc, prod_fix;
  logic              load, step, last;

  always_comb begin
    a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
               (funct3 == F3_DIV)  || (funct3 == F3_REM);
    b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    a_neg    = a_signed & SrcA[XLEN-1];
    b_neg    = b_signed & SrcB[XLEN-1];
    a_mag    = a_neg ? -SrcA : SrcA;
    b_mag    = b_neg ? -SrcB : SrcB;
    is_div   = funct3[2];
    div0     = is_div && (SrcB == '0);
    ovf      = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
               (SrcA == 32'h8000_0000) && (SrcB == 32'hFFFF_FFFF);
    if (div0)
      special_res = funct3[1] ? SrcA : '1;
    else
      special_res = funct3[1] ? '0 : 32'h8000_0000;
  end

  always_comb begin
    prod_fix = neg_q  ? -acc : acc;
    quot_fix = neg_q  ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = rneg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op_q)
      F3_MUL:                        fix_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  fix_res = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               fix_res = quot_fix;
      default:                       fix_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    load     = 1'b0;
    step     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          op_d = funct3;
          if (div0 || ovf) begin
            result_d = special_res;
            state_d  = ST_DONE;
          end else begin
            load    = 1'b1;
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
            state_d = ST_CALC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        step = 1'b1;
        if (last) state_d = ST_FIX;
      end
      ST_FIX: begin
        result_d = fix_res;
        state_d  = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  muldiv_iter_core u_core (
    .clk     (clk),
    .rst     (reset),
    .load    (load),
    .step    (step),
    .is_div  (is_div),
    .init_lo (is_div ? a_mag : b_mag),
    .opnd    (is_div ? b_mag : a_mag),
    .last    (last),
    .acc     (acc)
  );

  assign busy   = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign done   = (state_q == ST_DONE);
  assign Result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized scoreboard bench for muldiv_unit against an arithmetic reference.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] SrcA, SrcB;
  logic        busy, done;
  logic [31:0] Result;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          free_edge = 0;
  int          busy_lo = 1, busy_hi = 0;
  logic [31:0] hold_res = '0;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done), .Result(Result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    int     si, sj, qi;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    si = $signed(a);
    sj = $signed(b);
    case (f)
      3'd0: begin p = ua * ub; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin qi = si / sj; r = qi; end
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else begin qi = si % sj; r = qi; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Called just after a rising edge; the next edge is the candidate accept edge.
  task automatic op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int e, lat;
    exp_t x;
    start = 1'b1; funct3 = f; SrcA = a; SrcB = b;
    e = cyc + 1;
    if (e >= free_edge) begin
      lat   = ref_lat(f, a, b);
      x.res = ref_res(f, a, b);
      x.due = e + lat - 1;
      exp_q.push_back(x);
      if (lat == 34) begin busy_lo = e; busy_hi = e + 32; end
      free_edge = e + lat;
    end
    @(posedge clk); #1;
    start = 1'b0; funct3 = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
  endtask

  task automatic wait_free();
    while (cyc + 1 < free_edge) begin @(posedge clk); #1; end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Result !== 32'h0) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b Result=%h, required 0/0/00000000", tag, busy, done, Result);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    hold_res  = '0;
    free_edge = 0;
    busy_lo   = 1;
    busy_hi   = 0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
        checks++; errors++;
        $display("FAIL done_timeout: no done by cycle %0d, required at %0d", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
      checks++;
      if (busy !== (cyc >= busy_lo && cyc <= busy_hi)) begin
        errors++;
        $display("FAIL busy: cycle %0d busy=%b required %b", cyc, busy, (cyc >= busy_lo && cyc <= busy_hi));
      end
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_done: cycle %0d with no operation pending", cyc);
        end else begin
          checks += 2;
          if (cyc != exp_q[0].due) begin
            errors++;
            $display("FAIL done_latency: done at cycle %0d, required %0d", cyc, exp_q[0].due);
          end
          if (Result !== exp_q[0].res) begin
            errors++;
            $display("FAIL result: got %h required %h", Result, exp_q[0].res);
          end
          hold_res = exp_q[0].res;
          void'(exp_q.pop_front());
        end
      end else begin
        checks++;
        if (Result !== hold_res) begin
          errors++;
          $display("FAIL result_hold: cycle %0d Result=%h required %h", cyc, Result, hold_res);
        end
      end
    end
  end

  logic [2:0]  dir_f[12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
  logic [31:0] dir_a[12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                             32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] dir_b[12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                             32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  initial begin
    int e0, guard;
    reset = 1'b1; start = 1'b0; funct3 = '0; SrcA = '0; SrcB = '0;
    #12;
    check_idle_outputs("reset_state");
    #11 reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      wait_free();
      op(dir_f[i], dir_a[i], dir_b[i]);
    end

    // Second start lands mid-CALC and must be ignored.
    wait_free();
    op(3'd0, 32'h0000_1234, 32'h0000_5678);
    repeat (5) @(posedge clk);
    #1 op(3'd5, 32'hAAAA_5555, 32'd3);
    wait_free();
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        wait_free();
        repeat ($urandom_range(0, 2)) @(posedge clk);
        if (cyc + 1 >= free_edge) #1;
      end
      op(3'($urandom), pick_operand(), pick_operand());
    end

    // Asynchronous reset during iteration 10 of a multiply.
    wait_free();
    e0 = cyc + 1;
    op(3'd0, 32'h0000_DEAD, 32'h0000_BEEF);
    while (cyc < e0 + 10) @(posedge clk);
    #3 reset = 1'b1;
    #1 check_idle_outputs("async_reset_mid_calc");
    model_reset();
    #8 reset = 1'b0;
    @(posedge clk); #1;
    op(3'd0, 32'd3, 32'd4);

    guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin @(posedge clk); guard++; end
    @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d operations still pending, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit downstream of the ALU source-A select. Consumes SrcA (PC or RD1) and SrcB.
- Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with a start/busy/done handshake.
- The control unit stalls the PC while busy is high. Result feeds the writeback mux.

Parameters:
- XLEN, 32, operand and result width. Only 32 is supported.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse. Sampled on a rising edge of clk.
- funct3  input  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA  input  32  multiplicand/dividend, from the PC/RD1 select.
- SrcB  input  32  multiplier/divisor.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse. Result is valid while done is high.
- Result  output  32  operation result. Held until the next accepted start.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE; busy=0, done=0, Result=0.
  - Iteration counter and internal operand/accumulator registers cleared.
  - Operation resumes normally on the first edge after reset deasserts.
- States: IDLE, CALC, FIX, DONE.
- busy=1 in CALC and FIX only. done=1 in DONE only.
- Accept rule:
  - start is accepted on an edge where state is IDLE or DONE (allows back-to-back operations).
  - start in CALC or FIX is ignored, with no effect on the operation in flight.
  - On accept, funct3, SrcA and SrcB are captured. Inputs may change afterward without effect.
- Operand prep at accept:
  - Signed operands are converted to magnitudes.
  - Signedness: MULH both signed; MULHSU A signed, B unsigned; MULHU/DIVU/REMU unsigned. MUL low word is signedness-independent.
  - Result-sign flags are latched.
- Special cases at accept (go directly to DONE):
  - Divide by zero (funct3[2]=1, SrcB=0): quotient=0xFFFFFFFF, remainder=SrcA. Applies to both signed and unsigned.
  - Signed overflow (DIV/REM, SrcA=0x80000000, SrcB=0xFFFFFFFF): quotient=0x80000000, remainder=0.
  - done is high in the cycle after the accepting edge (latency 1).
- Normal path:
  - accept edge -> CALC, counter=0.
  - Each CALC edge performs one iteration:
    - Multiply: shift-add, 64-bit product accumulator.
    - Divide: restoring, one quotient bit per edge, 32-bit partial remainder.
  - After 32 iterations -> FIX.
  - FIX edge applies sign correction and selects Result -> DONE.
  - done is high 34 cycles after the accepting edge. busy is high for exactly 33 cycles.
- Sign correction:
  - Product: negated if the signed operand signs differ.
  - Quotient: negated if signs differ (signed DIV only).
  - Remainder: takes the dividend's sign (signed REM only).
- Result selection: MUL = product[31:0]; MULH* = product[63:32]; DIV* = quotient; REM* = remainder.
- DONE -> IDLE on the next edge unless start is accepted, in which case it enters CALC or DONE per the rules above.
- Result updates only on the FIX edge or a special-case accept edge. It is never cleared by returning to IDLE.
- All arithmetic is modulo 2^32/2^64. No exceptions or flags are raised.

Decomposition:
- Shared header/package holds:
  - funct3 localparams for the M extension.
  - Muldiv state encodings (IDLE/CALC/FIX/DONE, 2 bits).
  - XLEN.
- One natural sub-module: muldiv_iter_core.
  - Contains the 32-step shift-add/restoring datapath with counter and accumulator.
  - The parent muldiv_unit keeps the FSM, operand prep, special-case detect and sign fix.

Test Plan:
- MUL SrcA=7, SrcB=0xFFFFFFFD -> Result=0xFFFFFFEB; busy high 33 cycles; done single pulse 34 cycles after accept.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0. Each has done one cycle after accept and busy never asserted.
- Start pulsed during CALC with different operands -> ignored, original result returned. Start in DONE cycle -> new operation accepted back-to-back.
- Reset asserted mid-CALC (iteration 10), asynchronous to the clock edge -> busy/done/Result go 0 immediately. After release, MUL 3x4 -> 12 with full normal latency.
